nios_onchip_mem_pl: RTL
=======================

# nios_onchip_mem_pl

Parametrised, pipelined Avalon-MM on-chip data memory for the Nios master subsystem. It is the next generation of the fixed 32-bit, 2500-word single-port data RAM, with:
- generic width and depth;
- selectable read latency, signalled with readdatavalid;
- waitrequest-based stalling;
- hardware zero-clear after reset;
- out-of-range detection.

It sits on the master's data bus as a slave.

## Interface
- DATA_W, 32: data width; multiple of 8.
- ADDR_W, 12: word-address width.
- DEPTH, 2500: words implemented; 1 ≤ DEPTH ≤ 2^ADDR_W.
- READ_LATENCY, 1: 1 or 2; cycles from accepted read to readdatavalid.
- CLEAR_ON_RESET, 1: 1 zero-fills the array after reset; 0 skips the fill.
- clk  in  1  single clock.
- reset_n  in  1  asynchronous assert, active-low reset; release synchronised externally.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  write byte lanes.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable; 0 stalls the block.
- reset_req  in  1  reset-request hold-off; 1 stalls the block.
- waitrequest  out  1  command not accepted this cycle.
- readdata  out  DATA_W  read data; valid only with readdatavalid.
- readdatavalid  out  1  one-cycle strobe per accepted read.
- init_done  out  1  high once the clear completes; stays high until reset.
- addr_err  out  1  one-cycle pulse when an out-of-range access is accepted.
- parity_err  out  1  see Configuration.

## Operation
- FSM states: CLEAR, READY. Reset enters CLEAR when CLEAR_ON_RESET=1, else READY.
- CLEAR behaviour:
  - clr_addr counts 0..DEPTH-1, writing zero with all lanes enabled, one word per unstalled cycle.
  - After the write to DEPTH-1, the FSM goes to READY and sets init_done.
  - waitrequest=1 throughout CLEAR.
- READY: waitrequest = stall, where stall = ~clken | reset_req.
- Accept: chipselect & (read | write) & ~waitrequest at a rising edge.
- Write: lanes with byteenable=1 are updated; the other lanes are preserved.
- read & write asserted together: treated as a write only; no readdatavalid is issued.
- Out-of-range access (address ≥ DEPTH):
  - Write is dropped.
  - Read returns 0 with readdatavalid at the normal latency.
  - addr_err pulses the cycle after accept.
- Stall:
  - The RAM clock enable and all pipeline registers hold.
  - readdatavalid is forced to 0.
  - A held read is delivered on the first unstalled cycle once its latency count completes.
  - In CLEAR, clr_addr also holds.
- Reset mid-operation: in-flight reads are discarded with no readdatavalid. The clear restarts from address 0.

## Timing
- Reset values: waitrequest=1, readdata=0, readdatavalid=0, init_done=0 (1 when CLEAR_ON_RESET=0), addr_err=0, parity_err=0.
- Read accepted at edge N → readdatavalid and readdata at edge N+READ_LATENCY, excluding stalled cycles.
- Throughput: one access per cycle with no bubbles. Mixed read/write streams keep reads in order.
- Write at edge N, read of the same address accepted at N+1 → returns the new data.
- CLEAR duration: DEPTH unstalled cycles after reset release. The first command can be accepted DEPTH cycles after release.
- readdata is driven only from registers (the RAM output register, plus an extra stage when READ_LATENCY=2).

## Configuration
- NIOS_ONCHIP_MEM_PL_PARITY_EN defined:
  - One even-parity bit is stored per byte: lane width 9, array DATA_W+DATA_W/8.
  - The parity bit is written with its lane; CLEAR writes parity 0.
  - On a read, all lanes are checked. parity_err pulses with readdatavalid on any mismatch.
  - Out-of-range reads never flag parity_err.
- Not defined: array width DATA_W; parity_err tied 0.

## Structure
- Package nios_onchip_mem_pkg holds:
  - FSM state enum (ST_CLEAR, ST_READY);
  - localparams for lane count and stored lane width (8 or 9);
  - parity function.
- Sub-module nios_onchip_mem_pl_ram: inferred single-port byte-lane RAM with clock enable and registered read port; DEPTH × stored width.
- The top level holds the FSM, stall logic, latency/valid shift register, range check and parity check.

## Test plan
- Reset release, CLEAR_ON_RESET=1, DEPTH=16 → waitrequest high 16 cycles; init_done rises; every read of 0..15 returns 0.
- Write 0xDEADBEEF to address 5 with byteenable=4'b0101, over a prior value of 0x11223344 → a read returns 0x11AD33EF.
- Back-to-back reads of addresses 0..7 at READ_LATENCY=2 → eight consecutive readdatavalid pulses, in order, starting 2 cycles after the first accept.
- Read of address 2600 with DEPTH=2500 → readdata 0, readdatavalid after latency, one addr_err pulse; a write to 2600 leaves memory unchanged.
- clken low for 3 cycles while a read is in flight → no readdatavalid during the stall; correct data arrives on the first cycle after resume; waitrequest is high during the stall.
- Under the parity macro, force-flip one stored bit at address 9 → a read of 9 gives parity_err coincident with readdatavalid. Mid-CLEAR reset_n pulse → the clear restarts at 0 and init_done stays low.

Source files
------------

// File: rtl/nios_onchip_mem_pkg.sv
// nios_onchip_mem_pkg: FSM states, byte-lane geometry and parity helper for nios_onchip_mem_pl.
// NIOS_ONCHIP_MEM_PL_PARITY_EN widens each stored lane by one even-parity bit.
package nios_onchip_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  localparam int BYTE_W = 8;
`ifdef NIOS_ONCHIP_MEM_PL_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction
  function automatic logic par(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/nios_onchip_mem_pl_ram.sv
// nios_onchip_mem_pl_ram: single-port byte-lane RAM with clock enable and registered read port.
// Lane width follows NIOS_ONCHIP_MEM_PL_PARITY_EN through the package.
module nios_onchip_mem_pl_ram
  import nios_onchip_mem_pkg::*;
#(
  parameter int DEPTH = 2500,
  parameter int IW    = 12,
  parameter int LANES = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           ce,
  input  logic                           we,
  input  logic                           zero,
  input  logic [IW-1:0]                  addr,
  input  logic [LANES-1:0]               be,
  input  logic [LANES-1:0][LANE_W-1:0]   wdata,
  output logic [LANES-1:0][LANE_W-1:0]   q
);
  logic [LANES-1:0][LANE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (ce && we)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr][i] <= wdata[i];
  // zero substitutes for out-of-range reads so the index is never trusted past DEPTH
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (ce) q <= zero ? '0 : mem[addr];
endmodule

// File: rtl/nios_onchip_mem_pl.sv
// nios_onchip_mem_pl: pipelined Avalon-MM on-chip data memory with zero-clear, stall and range check.
// NIOS_ONCHIP_MEM_PL_PARITY_EN adds per-byte even parity and drives parity_err.
module nios_onchip_mem_pl
  import nios_onchip_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 2500,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic                  clken,
  input  logic                  reset_req,
  output logic                  waitrequest,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  init_done,
  output logic                  addr_err,
  output logic                  parity_err
);
  localparam int LANES = lane_count(DATA_W);
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e st;
  logic live, stall, clearing, acc, acc_rd, inr, v1, v2, vl;
  logic [IW-1:0] clr_addr;
  logic [LANES-1:0][LANE_W-1:0] wd, q, d2, dl;
  assign stall       = ~clken | reset_req;
  assign clearing    = st == ST_CLEAR;
  assign waitrequest = ~live | clearing | stall;
  assign acc         = chipselect & (read | write) & ~waitrequest;
  assign acc_rd      = acc & read & ~write;
  assign inr         = 32'(address) < 32'(DEPTH);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st        <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      live      <= 1'b0;
      clr_addr  <= '0;
      init_done <= CLEAR_ON_RESET == 0;
      addr_err  <= 1'b0;
    end else begin
      live     <= 1'b1;
      addr_err <= acc & ~inr;
      if (clearing && !stall) begin
        if (clr_addr == IW'(DEPTH - 1)) begin
          st        <= ST_READY;
          init_done <= 1'b1;
        end else clr_addr <= clr_addr + 1'b1;
      end
    end
  always_comb begin
    wd = '0;
    for (int i = 0; i < LANES; i++) begin
      wd[i][7:0] = writedata[i*8 +: 8];
`ifdef NIOS_ONCHIP_MEM_PL_PARITY_EN
      wd[i][8] = par(writedata[i*8 +: 8]);
`endif
    end
  end
  nios_onchip_mem_pl_ram #(.DEPTH(DEPTH), .IW(IW), .LANES(LANES)) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (~stall),
    .we      (clearing | (acc & write & inr)),
    .zero    (~clearing & ~inr),
    .addr    (clearing ? clr_addr : address[IW-1:0]),
    .be      (clearing ? {LANES{1'b1}} : byteenable),
    .wdata   (clearing ? '0 : wd),
    .q       (q)
  );
  // the whole read pipeline freezes under stall so a held read resumes in place
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      d2 <= '0;
    end else if (!stall) begin
      v1 <= acc_rd;
      v2 <= v1;
      d2 <= q;
    end
  assign vl            = READ_LATENCY == 2 ? v2 : v1;
  assign dl            = READ_LATENCY == 2 ? d2 : q;
  assign readdatavalid = vl & ~stall;
  always_comb begin
    readdata = '0;
    for (int i = 0; i < LANES; i++) readdata[i*8 +: 8] = dl[i][7:0];
  end
`ifdef NIOS_ONCHIP_MEM_PL_PARITY_EN
  logic o1, o2, ol, perr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o1 <= 1'b0;
      o2 <= 1'b0;
    end else if (!stall) begin
      o1 <= acc_rd & ~inr;
      o2 <= o1;
    end
  assign ol = READ_LATENCY == 2 ? o2 : o1;
  always_comb begin
    perr = 1'b0;
    for (int i = 0; i < LANES; i++) perr = perr | (dl[i][8] != par(dl[i][7:0]));
  end
  assign parity_err = readdatavalid & ~ol & perr;
`else
  assign parity_err = 1'b0;
`endif
endmodule
